// File: rtl/bdemux_reg_pkg.sv
// -----------------------------------------------------------------------------
// bdemux_reg_pkg
// Shared constants for the registered one-to-N demultiplexer.
//   MAX_COUNT      : largest supported number of consumers
//   MAX_INDEX_BITS : widest supported binary destination index
//   DROP_CNT_MAX   : saturation value of the discarded-beat counter
//   occ_t          : FIFO occupancy (0..2)
// The buffered entry layout is {idx[index_bits-1:0], data[width-1:0]}; it is
// declared as a packed struct inside bdemux_reg because its field widths
// follow that module's parameters.
// -----------------------------------------------------------------------------
package bdemux_reg_pkg;

  localparam int MAX_COUNT      = 16;
  localparam int MAX_INDEX_BITS = 4;

  localparam logic [7:0] DROP_CNT_MAX = 8'hFF;

  typedef logic [1:0] occ_t;
  localparam occ_t OCC_EMPTY = 2'd0;
  localparam occ_t OCC_FULL  = 2'd2;

endpackage

// File: rtl/bdemux_reg_to_select.sv
// -----------------------------------------------------------------------------
// to_select
// Binary index to one-hot select decoder (inverse of to_index). Purely
// combinational. An index outside 0..select_bits-1 decodes to all zeros.
// Ports:
//   i_idx [index_bits-1:0]  binary index
//   o_sel [select_bits-1:0] one-hot select
// -----------------------------------------------------------------------------
module to_select #(
  parameter int index_bits  = 2,
  parameter int select_bits = 4
) (
  input  logic [index_bits-1:0]  i_idx,
  output logic [select_bits-1:0] o_sel
);

  always_comb begin
    // NOTE: every combinational output gets a default before any conditional
    // assignment so no path leaves it unassigned (which would infer a latch).
    o_sel = '0;
    for (int k = 0; k < select_bits; k++) begin
      o_sel[k] = (32'(i_idx) == 32'(k));
    end
  end

endmodule

// File: rtl/bdemux_reg.sv
// -----------------------------------------------------------------------------
// bdemux_reg
// Registered one-to-N demultiplexer. A (binary index, data) beat from one
// producer is buffered in a 2-entry FIFO; the head beat is presented to exactly
// one of `count` consumers via a one-hot valid vector. Beats addressed to a
// non-existent consumer are accepted and discarded, and are recorded in a
// sticky error flag and a saturating counter.
// Ports:
//   clock, reset           rising-edge clock, synchronous active-high reset
//   in_valid/in_ready      producer handshake
//   in_idx, in_data        destination index and payload
//   out_valid[count-1:0]   one-hot valid of the head beat
//   out_ready[count-1:0]   per-consumer accept (only the head's bit matters)
//   out_data               head payload, shared by all consumers
//   drop_err               sticky: an out-of-range beat was discarded
//   drop_cnt[7:0]          saturating count of discarded beats
// -----------------------------------------------------------------------------
module bdemux_reg
  import bdemux_reg_pkg::*;
#(
  parameter int count      = 4,
  parameter int width      = 32,
  parameter int index_bits = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [index_bits-1:0] in_idx,
  input  logic [width-1:0]      in_data,
  output logic [count-1:0]      out_valid,
  input  logic [count-1:0]      out_ready,
  output logic [width-1:0]      out_data,
  output logic                  drop_err,
  output logic [7:0]            drop_cnt
);

  typedef struct packed {
    logic [index_bits-1:0] idx;
    logic [width-1:0]      data;
  } entry_t;

  // Clamping keeps the limit representable in the widened compare below.
  localparam int               COUNT_LIMIT = (count < MAX_COUNT) ? count : MAX_COUNT;
  localparam logic [MAX_INDEX_BITS:0] COUNT_EXT = (MAX_INDEX_BITS + 1)'(COUNT_LIMIT);

  entry_t           r_mem [2];
  logic             r_wptr;
  logic             r_rptr;
  occ_t             r_occ;
  logic [width-1:0] r_last;
  logic             r_drop_err;
  logic [7:0]       r_drop_cnt;

  logic [MAX_INDEX_BITS:0] w_idx_ext;
  logic                    w_accept;
  logic                    w_legal;
  logic                    w_push;
  logic                    w_drop;
  logic                    w_pop;
  logic                    w_not_empty;
  entry_t                  w_head;
  logic [count-1:0]        w_sel;

  // Ready depends only on registered occupancy, never on out_ready/in_valid.
  assign in_ready    = (r_occ != OCC_FULL);
  assign w_accept    = in_valid & in_ready;
  assign w_idx_ext   = (MAX_INDEX_BITS + 1)'(in_idx);
  assign w_legal     = (w_idx_ext < COUNT_EXT);
  assign w_push      = w_accept & w_legal;
  assign w_drop      = w_accept & ~w_legal;

  assign w_not_empty = (r_occ != OCC_EMPTY);
  assign w_head      = r_mem[r_rptr];

  to_select #(
    .index_bits  (index_bits),
    .select_bits (count)
  ) u_to_select (
    .i_idx (w_head.idx),
    .o_sel (w_sel)
  );

  // Only legal indices are stored, so a non-empty FIFO always decodes to
  // exactly one bit; masking by out_valid ignores ready from other consumers.
  assign out_valid = w_not_empty ? w_sel : '0;
  assign w_pop     = |(out_valid & out_ready);

  // When empty, out_data keeps showing the last popped payload.
  assign out_data  = w_not_empty ? w_head.data : r_last;

  assign drop_err  = r_drop_err;
  assign drop_cnt  = r_drop_cnt;

  // NOTE: the payload storage is not reset; occupancy gates every read of it,
  // so clearing it would only add reset fan-out without changing behaviour.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wptr] <= '{idx: in_idx, data: in_data};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_occ      <= OCC_EMPTY;
      r_last     <= '0;
      r_drop_err <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
        r_last <= w_head.data;
      end
      // Pop needs a non-empty FIFO and push a non-full one, so this never
      // leaves 0..2.
      r_occ <= r_occ + occ_t'(w_push) - occ_t'(w_pop);
      if (w_drop) begin
        r_drop_err <= 1'b1;
        if (r_drop_cnt != DROP_CNT_MAX) begin
          r_drop_cnt <= r_drop_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bdemux_reg.sv
// -----------------------------------------------------------------------------
// tb_bdemux_reg
// Drives two instances from shared stimulus: count=4 (all indices legal) and
// count=3 (index 3 is illegal). A queue-based reference model tracks each
// instance; every cycle all outputs are compared against it, with extra
// directed comparisons at the interesting points of each scenario.
// -----------------------------------------------------------------------------
module tb_bdemux_reg;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [1:0]  in_idx;
  logic [31:0] in_data;
  logic [3:0]  out_ready;

  logic        in_ready4, drop_err4;
  logic [3:0]  out_valid4;
  logic [31:0] out_data4;
  logic [7:0]  drop_cnt4;

  logic        in_ready3, drop_err3;
  logic [2:0]  out_valid3;
  logic [31:0] out_data3;
  logic [7:0]  drop_cnt3;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  bdemux_reg #(.count(4), .width(32), .index_bits(2)) u_dut4 (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready4),
    .in_idx    (in_idx),
    .in_data   (in_data),
    .out_valid (out_valid4),
    .out_ready (out_ready),
    .out_data  (out_data4),
    .drop_err  (drop_err4),
    .drop_cnt  (drop_cnt4)
  );

  bdemux_reg #(.count(3), .width(32), .index_bits(2)) u_dut3 (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready3),
    .in_idx    (in_idx),
    .in_data   (in_data),
    .out_valid (out_valid3),
    .out_ready (out_ready[2:0]),
    .out_data  (out_data3),
    .drop_err  (drop_err3),
    .drop_cnt  (drop_cnt3)
  );

  // Reference model: one FIFO of {idx, data} per instance, plus drop state.
  logic [33:0] mq [2][$];
  int          m_cnt  [2];
  bit          m_err  [2];
  logic [31:0] m_last [2];

  function automatic int cnt_of(input int d);
    return (d == 0) ? 4 : 3;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Applies the handshake rules at a clock edge using pre-edge model state.
  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        mq[d].delete();
        m_cnt[d]  = 0;
        m_err[d]  = 1'b0;
        m_last[d] = '0;
      end else begin
        bit can_push;
        logic [33:0] head;
        can_push = (mq[d].size() < 2);
        if (mq[d].size() > 0) begin
          head = mq[d][0];
          if (out_ready[head[33:32]]) begin
            m_last[d] = head[31:0];
            void'(mq[d].pop_front());
          end
        end
        if (in_valid && can_push) begin
          if (int'(in_idx) < cnt_of(d)) begin
            mq[d].push_back({in_idx, in_data});
          end else begin
            m_err[d] = 1'b1;
            if (m_cnt[d] < 255) m_cnt[d]++;
          end
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int d = 0; d < 2; d++) begin
      logic [31:0] exp_valid, exp_data;
      logic [31:0] obs_valid, obs_data, obs_ready, obs_err, obs_cnt;
      if (mq[d].size() > 0) begin
        exp_valid = 32'(1) << mq[d][0][33:32];
        exp_data  = mq[d][0][31:0];
      end else begin
        exp_valid = '0;
        exp_data  = m_last[d];
      end
      if (d == 0) begin
        obs_valid = 32'(out_valid4); obs_data = out_data4; obs_ready = 32'(in_ready4);
        obs_err   = 32'(drop_err4);  obs_cnt  = 32'(drop_cnt4);
      end else begin
        obs_valid = 32'(out_valid3); obs_data = out_data3; obs_ready = 32'(in_ready3);
        obs_err   = 32'(drop_err3);  obs_cnt  = 32'(drop_cnt3);
      end
      check($sformatf("%s.c%0d.out_valid", tag, cnt_of(d)), obs_valid, exp_valid);
      check($sformatf("%s.c%0d.out_data",  tag, cnt_of(d)), obs_data,  exp_data);
      check($sformatf("%s.c%0d.in_ready",  tag, cnt_of(d)), obs_ready, 32'(mq[d].size() < 2));
      check($sformatf("%s.c%0d.drop_err",  tag, cnt_of(d)), obs_err,   32'(m_err[d]));
      check($sformatf("%s.c%0d.drop_cnt",  tag, cnt_of(d)), obs_cnt,   32'(m_cnt[d]));
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clock);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_idx    = '0;
    in_data   = '0;
    out_ready = '0;

    // Reset, then idle.
    tick("reset");
    tick("reset");
    reset = 1'b0;
    tick("idle");
    check("idle.out_valid", 32'(out_valid4), 32'h0);
    check("idle.in_ready",  32'(in_ready4),  32'h1);
    check("idle.drop_cnt",  32'(drop_cnt4),  32'h0);

    // Single beat to consumer 2; it pops on the edge where it is shown.
    in_valid  = 1'b1;
    in_idx    = 2'd2;
    in_data   = 32'hA5A5_0002;
    out_ready = 4'b0100;
    tick("single");
    in_valid = 1'b0;
    check("single.out_valid", 32'(out_valid4), 32'h4);
    check("single.out_data",  out_data4,       32'hA5A5_0002);
    tick("single.pop");
    check("single.popped", 32'(out_valid4), 32'h0);

    // Backpressure: two beats fill the FIFO, a third is refused.
    out_ready = 4'b0000;
    in_valid  = 1'b1;
    in_idx    = 2'd1;
    in_data   = 32'h1111_0001;
    tick("bp.push1");
    in_idx    = 2'd3;
    in_data   = 32'h3333_0003;
    tick("bp.push2");
    check("bp.full.in_ready", 32'(in_ready4), 32'h0);
    in_idx    = 2'd0;
    in_data   = 32'h0BAD_0000;
    tick("bp.refused");
    check("bp.refused.in_ready",  32'(in_ready4),  32'h0);
    check("bp.refused.out_valid", 32'(out_valid4), 32'h2);
    in_valid  = 1'b0;
    out_ready = 4'b0010;
    tick("bp.pop");
    check("bp.pop.in_ready",  32'(in_ready4),  32'h1);
    check("bp.pop.out_valid", 32'(out_valid4), 32'h8);
    out_ready = 4'b1000;
    tick("bp.drain");

    // Streaming: back-to-back beats with every consumer ready.
    out_ready = 4'b1111;
    in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_idx  = 2'(i % 4);
      in_data = 32'h5700_0000 + 32'(i);
      tick("stream");
      check("stream.out_valid", 32'(out_valid4), 32'(1) << (i % 4));
      check("stream.out_data",  out_data4,       32'h5700_0000 + 32'(i));
      check("stream.in_ready",  32'(in_ready4),  32'h1);
    end
    in_valid = 1'b0;
    tick("stream.drain");
    tick("stream.drain");

    // Wrong-consumer ready: head for consumer 0 must hold.
    out_ready = 4'b0000;
    in_valid  = 1'b1;
    in_idx    = 2'd0;
    in_data   = 32'hDEAD_0000;
    tick("wrong.push");
    in_valid  = 1'b0;
    out_ready = 4'b1110;
    for (int i = 0; i < 5; i++) begin
      tick("wrong.hold");
      check("wrong.out_valid", 32'(out_valid4), 32'h1);
      check("wrong.out_data",  out_data4,       32'hDEAD_0000);
    end
    out_ready = 4'b0001;
    tick("wrong.pop");
    check("wrong.popped", 32'(out_valid4), 32'h0);

    // Randomised traffic against the model.
    for (int i = 0; i < 200; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_idx    = 2'($urandom_range(0, 3));
      in_data   = $urandom;
      out_ready = 4'($urandom_range(0, 15));
      tick("random");
    end

    // Illegal index on the count=3 instance until the counter saturates.
    out_ready = 4'b0111;
    in_valid  = 1'b1;
    in_idx    = 2'd3;
    for (int i = 0; i < 300; i++) begin
      in_data = $urandom;
      tick("illegal");
    end
    check("illegal.out_valid", 32'(out_valid3), 32'h0);
    check("illegal.drop_err",  32'(drop_err3),  32'h1);
    check("illegal.drop_cnt",  32'(drop_cnt3),  32'd255);

    // Fill the count=3 instance, then reset mid-stream.
    out_ready = 4'b0000;
    in_idx    = 2'd0;
    in_data   = 32'hF111_0000;
    tick("fill");
    in_data   = 32'hF222_0000;
    tick("fill");
    check("fill.in_ready", 32'(in_ready3), 32'h0);
    in_valid = 1'b0;
    reset    = 1'b1;
    tick("midreset");
    reset    = 1'b0;
    check("midreset.out_valid", 32'(out_valid3), 32'h0);
    check("midreset.drop_err",  32'(drop_err3),  32'h0);
    check("midreset.drop_cnt",  32'(drop_cnt3),  32'h0);
    check("midreset.in_ready",  32'(in_ready3),  32'h1);
    tick("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
